// File: rtl/traffic_safety_monitor.sv
// Safety monitor between the traffic light sequencer and the lamp drivers.
// Passes lamp codes through one register stage; on any violation latches a fault and forces a safe pattern.
module traffic_safety_monitor #(
   parameter int unsigned MIN_GREEN  = 10,
   parameter int unsigned MIN_LEFT   = 5,
   parameter int unsigned MIN_RED    = 20,
   parameter int unsigned YELLOW_LEN = 2,
   parameter int unsigned BLINK_HALF = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] i_car_traffic,
   input  logic [1:0] i_walker_traffic,
   input  logic       i_fault_clr,
   output logic [3:0] o_car_lamp,
   output logic [1:0] o_walker_lamp,
   output logic       o_fault,
   output logic [2:0] o_fault_code
);

   localparam int unsigned CNT_W   = 7;
   localparam int unsigned BLINK_W = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;

   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   YEL_CNT    = CNT_W'(YELLOW_LEN);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
   localparam logic [BLINK_W-1:0] BLINK_MID  = BLINK_W'(BLINK_HALF);

   localparam logic [3:0] C_RED  = 4'b1000;
   localparam logic [3:0] C_YEL  = 4'b0100;
   localparam logic [3:0] C_LEFT = 4'b0010;
   localparam logic [3:0] C_GRN  = 4'b0001;
   localparam logic [3:0] C_NONE = 4'b0000;
   localparam logic [1:0] W_RED  = 2'b10;
   localparam logic [1:0] W_GRN  = 2'b01;
   localparam logic [1:0] W_NONE = 2'b00;

   localparam logic [2:0] F_NONE     = 3'd0;
   localparam logic [2:0] F_ILLEGAL  = 3'd1;
   localparam logic [2:0] F_SEQ      = 3'd2;
   localparam logic [2:0] F_DWELL    = 3'd3;
   localparam logic [2:0] F_CONFLICT = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_GREEN, S_Y1, S_LEFT, S_Y2, S_RED, S_FAULT} state_t;

   state_t             r_state, w_state_nxt, w_phase_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_min;
   logic [BLINK_W-1:0] r_blink, w_blink_nxt;
   logic               r_first, w_first_nxt;
   logic [3:0]         w_car_nxt, w_cur_code, w_exp_code;
   logic [1:0]         w_walker_nxt;
   logic               w_fault_nxt;
   logic [2:0]         w_code_nxt;
   logic               w_is_yel, w_illegal, w_conflict, w_seq_err, w_dwell_err;

   // Per-phase expectations: code held in this phase, code of the legal successor, minimum dwell
   always_comb begin
      w_cur_code  = C_NONE;
      w_exp_code  = C_NONE;
      w_phase_nxt = r_state;
      w_min       = '0;
      case (r_state)
         S_GREEN: begin w_cur_code = C_GRN;  w_exp_code = C_YEL;  w_phase_nxt = S_Y1;    w_min = CNT_W'(MIN_GREEN); end
         S_Y1:    begin w_cur_code = C_YEL;  w_exp_code = C_LEFT; w_phase_nxt = S_LEFT;  end
         S_LEFT:  begin w_cur_code = C_LEFT; w_exp_code = C_YEL;  w_phase_nxt = S_Y2;    w_min = CNT_W'(MIN_LEFT); end
         S_Y2:    begin w_cur_code = C_YEL;  w_exp_code = C_RED;  w_phase_nxt = S_RED;   end
         S_RED:   begin w_cur_code = C_RED;  w_exp_code = C_GRN;  w_phase_nxt = S_GREEN; w_min = CNT_W'(MIN_RED); end
         default: ;
      endcase
   end

   assign w_is_yel   = (r_state == S_Y1) || (r_state == S_Y2);
   assign w_illegal  = !$onehot0(i_car_traffic) || (i_walker_traffic == 2'b11);
   assign w_conflict = ((i_walker_traffic == W_GRN) && (i_car_traffic != C_RED)) ||
                       ((i_walker_traffic == W_NONE) && (i_car_traffic != C_NONE) && (i_car_traffic != C_RED));

   // Next state, counters and registered lamp/fault values
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_first_nxt  = r_first;
      w_blink_nxt  = r_blink;
      w_car_nxt    = i_car_traffic;
      w_walker_nxt = i_walker_traffic;
      w_fault_nxt  = o_fault;
      w_code_nxt   = o_fault_code;
      w_seq_err    = 1'b0;
      w_dwell_err  = 1'b0;

      if (r_state == S_FAULT) begin
         w_blink_nxt  = (r_blink == BLINK_LAST) ? '0 : r_blink + BLINK_W'(1);
         w_car_nxt    = (w_blink_nxt < BLINK_MID) ? C_YEL : C_NONE;
         w_walker_nxt = W_RED;
         if (i_fault_clr && (i_car_traffic == C_NONE) && (i_walker_traffic == W_NONE)) begin
            w_state_nxt  = S_IDLE;
            w_fault_nxt  = 1'b0;
            w_code_nxt   = F_NONE;
            w_car_nxt    = C_NONE;
            w_walker_nxt = W_NONE;
            w_blink_nxt  = '0;
            w_cnt_nxt    = '0;
            w_first_nxt  = 1'b0;
         end
      end else begin
         if (r_state == S_IDLE) begin
            if (i_car_traffic == C_GRN) begin
               w_state_nxt = S_GREEN; w_cnt_nxt = CNT_W'(1); w_first_nxt = 1'b1;
            end else if (i_car_traffic == C_YEL) begin
               w_state_nxt = S_Y2;    w_cnt_nxt = CNT_W'(1); w_first_nxt = 1'b1;
            end else if (i_car_traffic != C_NONE) begin
               w_seq_err = 1'b1;
            end
         end else if (i_car_traffic == C_NONE) begin
            w_state_nxt = S_IDLE; w_cnt_nxt = '0; w_first_nxt = 1'b0;
         end else if (i_car_traffic == w_cur_code) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
            // Overstayed yellow is flagged on the cycle it happens, not when it ends
            if (w_is_yel && !r_first && (r_cnt == YEL_CNT)) w_dwell_err = 1'b1;
         end else if (i_car_traffic == w_exp_code) begin
            w_state_nxt = w_phase_nxt; w_cnt_nxt = CNT_W'(1); w_first_nxt = 1'b0;
            if (!r_first) w_dwell_err = w_is_yel ? (r_cnt != YEL_CNT) : (r_cnt < w_min);
         end else begin
            w_seq_err = 1'b1;
         end

         if (w_illegal || w_conflict || w_seq_err || w_dwell_err) begin
            w_state_nxt  = S_FAULT;
            w_fault_nxt  = 1'b1;
            w_code_nxt   = w_illegal ? F_ILLEGAL : w_conflict ? F_CONFLICT : w_seq_err ? F_SEQ : F_DWELL;
            w_blink_nxt  = '0;
            w_cnt_nxt    = '0;
            w_first_nxt  = 1'b0;
            w_car_nxt    = C_YEL;
            w_walker_nxt = W_RED;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_blink       <= '0;
         r_first       <= 1'b0;
         o_car_lamp    <= C_NONE;
         o_walker_lamp <= W_NONE;
         o_fault       <= 1'b0;
         o_fault_code  <= F_NONE;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_blink       <= w_blink_nxt;
         r_first       <= w_first_nxt;
         o_car_lamp    <= w_car_nxt;
         o_walker_lamp <= w_walker_nxt;
         o_fault       <= w_fault_nxt;
         o_fault_code  <= w_code_nxt;
      end
   end

endmodule
